// File: rtl/histogram_engine.sv
// histogram_engine: single-channel histogram accumulator.
// Counts one bin index per clock into a dual-port RAM using a 3-stage
// read-modify-write pipeline with forwarding. It also provides an
// automatic clear sweep, saturation/wrap status, a running pixel total
// and a random-access readout that shares RAM port A with the pixel path.
module histogram_engine #(
   parameter int BIN_BITS = 8,
   parameter int COUNT_W  = 20,
   parameter int SATURATE = 1
) (
   input  logic                        iClk,
   input  logic                        iRst,
   input  logic                        iClear,
   input  logic [BIN_BITS-1:0]         iBin,
   input  logic                        iValid,
   input  logic                        iRdEn,
   input  logic [BIN_BITS-1:0]         iRdAddr,
   output logic [COUNT_W-1:0]          oRdData,
   output logic                        oRdValid,
   output logic                        oBusy,
   output logic                        oClearDone,
   output logic                        oSat,
   output logic [COUNT_W+BIN_BITS-1:0] oTotal
);

   localparam int                 NB      = 1 << BIN_BITS;
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [0:0]         ST_ACCUM = 1'b0;
   localparam logic [0:0]         ST_CLEAR = 1'b1;

   logic [0:0]          state;
   logic [BIN_BITS-1:0] clr_addr;
   logic [COUNT_W-1:0]  mem [NB];

   // Stage 0 carries either a pixel or a readout address; they never
   // coexist because a read is only taken when no pixel arrives.
   logic                s0_vld, s0_rd;
   logic [BIN_BITS-1:0] s0_bin;
   logic                s1_vld, s1_rd;
   logic [BIN_BITS-1:0] s1_bin;
   logic [COUNT_W-1:0]  ram_q;
   logic                s2_vld;
   logic [BIN_BITS-1:0] s2_bin;
   logic [COUNT_W-1:0]  s2_cnt;
   // Copy of the write that landed on the previous edge; a RAM read on
   // that same edge returned the stale value.
   logic                w_vld;
   logic [BIN_BITS-1:0] w_bin;
   logic [COUNT_W-1:0]  w_cnt;

   logic               accum, pix_acc, rd_acc, at_max;
   logic [COUNT_W-1:0] old_cnt, new_cnt;

   assign accum   = (state == ST_ACCUM);
   assign pix_acc = accum & iValid & ~iClear;
   assign rd_acc  = accum & iRdEn & ~iValid & ~iClear;
   assign oBusy   = (state == ST_CLEAR);

   // Pick the freshest count for the stage-1 bin: pending write first,
   // then the write just committed, else the RAM data.
   always_comb begin
      old_cnt = ram_q;
      if (s2_vld && (s2_bin == s1_bin))
         old_cnt = s2_cnt;
      else if (w_vld && (w_bin == s1_bin))
         old_cnt = w_cnt;
      at_max  = (old_cnt == CNT_MAX);
      new_cnt = old_cnt + COUNT_W'(1);
      if ((SATURATE != 0) && at_max)
         new_cnt = CNT_MAX;
   end

   // Sweep control: iClear restarts at bin 0, last bin returns to ACCUM.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state      <= ST_CLEAR;
         clr_addr   <= '0;
         oClearDone <= 1'b0;
      end else begin
         oClearDone <= 1'b0;
         if (iClear) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
         end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + BIN_BITS'(1);
            if (clr_addr == {BIN_BITS{1'b1}}) begin
               state      <= ST_ACCUM;
               oClearDone <= 1'b1;
            end
         end
      end
   end

   // Port B: sweep zeroes, otherwise commit the stage-2 count.
   always_ff @(posedge iClk) begin
      if (state == ST_CLEAR)
         mem[clr_addr] <= '0;
      else if (s2_vld && !iClear)
         mem[s2_bin] <= s2_cnt;
   end

   // Port A: shared synchronous read for pixels and readout.
   always_ff @(posedge iClk) begin
      ram_q <= mem[s0_bin];
   end

   // Pipeline registers; iClear flushes everything in flight.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         s0_vld   <= 1'b0;
         s0_rd    <= 1'b0;
         s0_bin   <= '0;
         s1_vld   <= 1'b0;
         s1_rd    <= 1'b0;
         s1_bin   <= '0;
         s2_vld   <= 1'b0;
         s2_bin   <= '0;
         s2_cnt   <= '0;
         w_vld    <= 1'b0;
         w_bin    <= '0;
         w_cnt    <= '0;
         oRdValid <= 1'b0;
         oRdData  <= '0;
      end else begin
         s0_vld   <= pix_acc;
         s0_rd    <= rd_acc;
         s0_bin   <= rd_acc ? iRdAddr : iBin;
         s1_vld   <= s0_vld & ~iClear;
         s1_rd    <= s0_rd & ~iClear;
         s1_bin   <= s0_bin;
         s2_vld   <= s1_vld & ~iClear;
         s2_bin   <= s1_bin;
         s2_cnt   <= new_cnt;
         w_vld    <= s2_vld & ~iClear;
         w_bin    <= s2_bin;
         w_cnt    <= s2_cnt;
         oRdValid <= s1_rd & ~iClear;
         if (s1_rd)
            oRdData <= ram_q;
      end
   end

   // Running total and sticky overflow flag, zeroed throughout a sweep.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oTotal <= '0;
         oSat   <= 1'b0;
      end else if (iClear || state == ST_CLEAR) begin
         oTotal <= '0;
         oSat   <= 1'b0;
      end else begin
         if (s0_vld)
            oTotal <= oTotal + (COUNT_W+BIN_BITS)'(1);
         if (s1_vld && at_max)
            oSat <= 1'b1;
      end
   end

endmodule

// File: tb/tb_histogram_engine.sv
// Bench for histogram_engine: three instances (20-bit saturating, 4-bit
// saturating, 4-bit wrapping) share stimulus. A raw per-bin pixel count
// model derives each instance's expected readout; reads push expectations
// to a scoreboard that is drained when oRdValid appears.
module tb_histogram_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1, clr = 1'b0, vld = 1'b0, rd_en = 1'b0;
   logic [7:0] bin = '0, rd_addr = '0;

   logic [19:0] rd_data0;
   logic [3:0]  rd_data1, rd_data2;
   logic        rd_valid0, rd_valid1, rd_valid2;
   logic        busy0, busy1, busy2, done0, done1, done2, sat0, sat1, sat2;
   logic [27:0] total0;
   logic [11:0] total1, total2;

   always #5 clk = ~clk;

   histogram_engine #(.BIN_BITS(8), .COUNT_W(20), .SATURATE(1)) u_d0 (
      .iClk(clk), .iRst(rst), .iClear(clr), .iBin(bin), .iValid(vld),
      .iRdEn(rd_en), .iRdAddr(rd_addr), .oRdData(rd_data0), .oRdValid(rd_valid0),
      .oBusy(busy0), .oClearDone(done0), .oSat(sat0), .oTotal(total0));
   histogram_engine #(.BIN_BITS(8), .COUNT_W(4), .SATURATE(1)) u_d1 (
      .iClk(clk), .iRst(rst), .iClear(clr), .iBin(bin), .iValid(vld),
      .iRdEn(rd_en), .iRdAddr(rd_addr), .oRdData(rd_data1), .oRdValid(rd_valid1),
      .oBusy(busy1), .oClearDone(done1), .oSat(sat1), .oTotal(total1));
   histogram_engine #(.BIN_BITS(8), .COUNT_W(4), .SATURATE(0)) u_d2 (
      .iClk(clk), .iRst(rst), .iClear(clr), .iBin(bin), .iValid(vld),
      .iRdEn(rd_en), .iRdAddr(rd_addr), .oRdData(rd_data2), .oRdValid(rd_valid2),
      .oBusy(busy2), .oClearDone(done2), .oSat(sat2), .oTotal(total2));

   typedef struct {
      int     due;
      int     addr;
      longint e0, e1, e2;
   } rd_exp_t;

   rd_exp_t sb[$];
   rd_exp_t sb_e;
   int      checks = 0, errors = 0;
   int      cyc = 0, nvalid = 0;
   int      cnt[256];
   int      total_n = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic longint exp_cnt(input int n, input int w, input int satm);
      longint mx;
      mx = (64'd1 << w) - 1;
      if (satm != 0) return (n > mx) ? mx : longint'(n);
      return longint'(n) % (mx + 1);
   endfunction

   function automatic bit exp_sat(input int w);
      for (int i = 0; i < 256; i++)
         if (longint'(cnt[i]) > ((64'd1 << w) - 1)) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Read monitor: every oRdValid must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && (rd_valid0 || rd_valid1 || rd_valid2)) begin
         nvalid++;
         chk("rd_valid_agree", {rd_valid1, rd_valid2}, {rd_valid0, rd_valid0});
         if (sb.size() == 0)
            chk("rd_unexpected", 1, 0);
         else begin
            sb_e = sb.pop_front();
            chk("rd_latency", cyc, sb_e.due);
            chk($sformatf("rd0_bin%0d", sb_e.addr), rd_data0, sb_e.e0);
            chk($sformatf("rd1_bin%0d", sb_e.addr), rd_data1, sb_e.e1);
            chk($sformatf("rd2_bin%0d", sb_e.addr), rd_data2, sb_e.e2);
         end
      end
   end

   task automatic pix(input int b);
      vld = 1'b1;
      bin = 8'(b);
      @(negedge clk);
      vld = 1'b0;
      cnt[b]++;
      total_n++;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input int a, input bit ok);
      rd_exp_t e;
      rd_en   = 1'b1;
      rd_addr = 8'(a);
      if (ok) begin
         e.due  = cyc + 3;
         e.addr = a;
         e.e0   = exp_cnt(cnt[a], 20, 1);
         e.e1   = exp_cnt(cnt[a], 4, 1);
         e.e2   = exp_cnt(cnt[a], 4, 0);
         sb.push_back(e);
      end
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy0 && n < 5000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_status(input string pfx);
      chk({pfx, "_total0"}, total0, longint'(total_n) % (64'd1 << 28));
      chk({pfx, "_total1"}, total1, longint'(total_n) % (64'd1 << 12));
      chk({pfx, "_total2"}, total2, longint'(total_n) % (64'd1 << 12));
      chk({pfx, "_sat"}, {sat0, sat1, sat2}, {exp_sat(20), exp_sat(4), exp_sat(4)});
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) cnt[i] = 0;
      total_n = 0;
   endtask

   task automatic do_clear();
      int n;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_clear();
      count_busy(n);
      chk("clear_busy_len", n, 256);
      chk("clear_done", {done0, done1, done2}, 3'b111);
      @(negedge clk);
      chk("clear_done_1cyc", {done0, done1, done2}, 3'b000);
   endtask

   initial begin
      int n, m, nv;
      model_clear();
      // Reset values
      idle(3);
      chk("rst_busy", {busy0, busy1, busy2}, 3'b111);
      chk("rst_done", {done0, done1, done2}, 3'b000);
      chk("rst_rdvalid", {rd_valid0, rd_valid1, rd_valid2}, 3'b000);
      chk("rst_rddata", rd_data0, 0);
      check_status("rst");
      rst = 1'b0;
      count_busy(n);
      chk("rst_busy_len", n, 256);
      chk("rst_clear_done", {done0, done1, done2}, 3'b111);
      @(negedge clk);
      chk("rst_clear_done_1cyc", {done0, done1, done2}, 3'b000);

      // Post-reset bins are zero
      rd(0, 1); rd(127, 1); rd(255, 1);
      idle(4);

      // Long run into one bin
      for (int i = 0; i < 1000; i++) pix(42);
      idle(3);
      rd(42, 1); rd(41, 1); rd(43, 1);
      idle(4);
      check_status("run42");

      // Forwarding at distance 1 and 2
      pix(5); pix(5); pix(6); pix(5); pix(6); pix(6);
      idle(3);
      rd(5, 1); rd(6, 1);
      idle(4);
      check_status("fwd");

      // Saturation boundary
      do_clear();
      check_status("clr_a");
      for (int i = 0; i < 15; i++) pix(3);
      idle(3);
      check_status("sat15");
      for (int i = 0; i < 5; i++) pix(3);
      idle(3);
      rd(3, 1);
      idle(4);
      check_status("sat20");

      // Readout dropped when a pixel arrives in the same cycle
      nv = nvalid;
      vld = 1'b1; bin = 8'd9; rd_en = 1'b1; rd_addr = 8'd9;
      @(negedge clk);
      vld = 1'b0; rd_en = 1'b0;
      cnt[9]++; total_n++;
      idle(5);
      chk("drop_rd_with_pixel", nvalid, nv);
      rd(9, 1);
      idle(4);

      // Clear with two pixels in flight, second clear mid-sweep, reads
      // requested during the sweep
      pix(7); pix(7);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_clear();
      nv = nvalid;
      n = 0;
      for (int i = 0; i < 99; i++) begin
         if (busy0) n++;
         rd_en = 1'b1;
         rd_addr = 8'(i);
         @(negedge clk);
      end
      rd_en = 1'b0;
      if (busy0) n++;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      count_busy(m);
      chk("dbl_clear_busy_len", n + m, 356);
      chk("dbl_clear_done", {done0, done1, done2}, 3'b111);
      chk("drop_rd_busy", nvalid, nv);
      check_status("dbl_clear");
      for (int i = 0; i < 256; i++) rd(i, 1);
      idle(5);
      chk("sb_drained", sb.size(), 0);
      check_status("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
